// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared default widths and the FSM state type for dram_arbiter.
package dram_arb_pkg;

  localparam int AW_DEFAULT = 20;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dram_arbiter_rr_grant.sv
// rr_grant: combinational one-hot grant plus winner index from a request vector.
// With DRAM_ARB_RR_EN defined the search starts at i_ptr and wraps; otherwise
// the lowest requesting index wins and there is no pointer input.
module rr_grant #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
`ifdef DRAM_ARB_RR_EN
  input  logic [IW-1:0]   i_ptr,
`endif
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);

  // First requester found in search order wins.
  always_comb begin
    logic        w_found;
    int unsigned w_j;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef DRAM_ARB_RR_EN
      w_j = (32'(i_ptr) + k) % NREQ;
`else
      w_j = k;
`endif
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one dram_ori port among NREQ requesters, one command in
// flight at a time (IDLE -> ISSUE -> [WAIT] -> IDLE).
// Build option: define DRAM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with requester 0 highest.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_raddr,
  output logic [AW-1:0]      mem_waddr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [NREQ-1:0]   w_grant;
  logic [NREQ-1:0]   w_ready;
  logic [IW-1:0]     w_win;
  logic              w_hs;
  logic              w_win_we;
  logic [AW-1:0]     w_win_addr;
  logic [DW-1:0]     w_win_wdata;

  logic [IW-1:0]     r_idx;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [AW-1:0]     r_mem_raddr;
  logic [AW-1:0]     r_mem_waddr;
  logic [DW-1:0]     r_mem_wdata;
  logic [DW-1:0]     r_rsp_rdata;
  logic [NREQ-1:0]   r_rsp_valid;

`ifdef DRAM_ARB_RR_EN
  logic [IW-1:0]     r_ptr;
`endif

  rr_grant #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_grant (
    .i_req   (req_valid),
`ifdef DRAM_ARB_RR_EN
    .i_ptr   (r_ptr),
`endif
    .o_grant (w_grant),
    .o_idx   (w_win)
  );

  assign w_win_we    = req_we[w_win];
  assign w_win_addr  = req_addr[w_win*AW +: AW];
  assign w_win_wdata = req_wdata[w_win*DW +: DW];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and ready: grants are offered only in IDLE and never during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) w_ready = w_grant;
        w_hs = |(w_ready & req_valid);
        if (w_hs) w_state_nxt = ISSUE;
      end
      ISSUE:   w_state_nxt = r_mem_ren ? WAIT : IDLE;
      WAIT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes are registered at the handshake edge so they occupy exactly the ISSUE
  // cycle; the WAIT cycle's edge captures read data and raises the response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_raddr <= '0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_mem_ren   <= w_hs & ~w_win_we;
      r_mem_wen   <= w_hs & w_win_we;
      r_rsp_valid <= '0;
      if (w_hs) begin
        r_idx <= w_win;
        if (w_win_we) begin
          r_mem_waddr <= w_win_addr;
          r_mem_wdata <= w_win_wdata;
        end else begin
          r_mem_raddr <= w_win_addr;
        end
      end
      if (r_state == WAIT) begin
        r_rsp_rdata        <= mem_rdata;
        r_rsp_valid[r_idx] <= 1'b1;
      end
    end
  end

`ifdef DRAM_ARB_RR_EN
  // Round-robin pointer: search restarts just past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`endif

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_raddr = r_mem_raddr;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized stimulus for dram_arbiter, checked
// every cycle against a transaction-timeline reference model.
module tb_dram_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 20;
  localparam int DW   = 8;
  localparam int MAXC = 4096;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               mem_ren;
  logic               mem_wen;
  logic [AW-1:0]      mem_raddr;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  dram_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Background content of never-written locations.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h5, a[19:16]};
  endfunction

  // dram_ori stand-in: registered read, write on strobe.
  logic [DW-1:0] dram [int];
  always @(posedge clk) begin
    if (mem_ren === 1'b1)
      mem_rdata <= dram.exists(int'(mem_raddr)) ? dram[int'(mem_raddr)] : init_val(mem_raddr);
    if (mem_wen === 1'b1)
      dram[int'(mem_waddr)] = mem_wdata;
  end

  // Requester command slots (held until accepted or withdrawn).
  logic          c_v    [NREQ];
  logic          c_we   [NREQ];
  logic [AW-1:0] c_addr [NREQ];
  logic [DW-1:0] c_data [NREQ];

  // Reference model: expected events per cycle number, plus held output values.
  logic [DW-1:0]   ref_mem [int];
  logic            e_ren   [MAXC];
  logic            e_wen   [MAXC];
  logic [AW-1:0]   e_addr  [MAXC];
  logic [DW-1:0]   e_data  [MAXC];
  logic [NREQ-1:0] e_rsp   [MAXC];
  logic [DW-1:0]   e_rdata [MAXC];
  int              m_free;
  int              m_ptr;
  logic [AW-1:0]   m_raddr, m_waddr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [NREQ-1:0] prev_rsp;

  int cyc;
  int vectors;
  int miscompares;
  int rsp_seen;
  int rsp_exp;
  int dut_acc [$];
  int dut_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic int model_winner();
    if (cyc < m_free) return -1;
    for (int k = 0; k < NREQ; k++) begin
`ifdef DRAM_ARB_RR_EN
      int i = (m_ptr + k) % NREQ;
`else
      int i = k;
`endif
      if (c_v[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = c_v[i];
      req_we[i]               = c_we[i];
      req_addr[i*AW +: AW]    = c_addr[i];
      req_wdata[i*DW +: DW]   = c_data[i];
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step();
    int win;
    logic [NREQ-1:0] exp_ready;
    drive();
    @(negedge clk);
    if (e_ren[cyc]) m_raddr = e_addr[cyc];
    if (e_wen[cyc]) begin m_waddr = e_addr[cyc]; m_wdata = e_data[cyc]; end
    if (e_rsp[cyc] != '0) m_rdata = e_rdata[cyc];
    win = rst ? -1 : model_winner();
    if (!rst) begin
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("mem_ren",   32'(mem_ren),   32'(e_ren[cyc]));
      check("mem_wen",   32'(mem_wen),   32'(e_wen[cyc]));
      check("mem_raddr", 32'(mem_raddr), 32'(m_raddr));
      check("mem_waddr", 32'(mem_waddr), 32'(m_waddr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rsp[cyc]));
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("ren_wen_excl",  32'(mem_ren & mem_wen),   32'd0);
      check("rsp_pulse",     32'(prev_rsp & rsp_valid), 32'd0);
      if (e_rsp[cyc] != '0) rsp_exp++;
      if (rsp_valid != '0) rsp_seen++;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] === 1'b1) begin dut_acc.push_back(i); dut_cyc.push_back(cyc); end
    end
    if (win >= 0) begin
      e_addr[cyc+1] = c_addr[win];
      if (c_we[win]) begin
        e_wen[cyc+1]  = 1'b1;
        e_data[cyc+1] = c_data[win];
        ref_mem[int'(c_addr[win])] = c_data[win];
        m_free = cyc + 2;
      end else begin
        e_ren[cyc+1]        = 1'b1;
        e_rsp[cyc+3]        = '0;
        e_rsp[cyc+3][win]   = 1'b1;
        e_rdata[cyc+3]      = ref_rd(c_addr[win]);
        m_free = cyc + 3;
      end
      m_ptr = (win + 1) % NREQ;
      c_v[win] = 1'b0;
    end
    prev_rsp = rsp_valid;
    if (rst) begin
      for (int k = 1; k <= 3; k++) begin
        e_ren[cyc+k] = 1'b0; e_wen[cyc+k] = 1'b0; e_rsp[cyc+k] = '0;
      end
      m_free = cyc + 1; m_ptr = 0; prev_rsp = '0;
      m_raddr = '0; m_waddr = '0; m_wdata = '0; m_rdata = '0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic arm(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_v[i] = 1'b1; c_we[i] = we; c_addr[i] = a; c_data[i] = d;
  endtask

  initial begin
    int n0;
    vectors = 0; miscompares = 0; cyc = 0; rsp_seen = 0; rsp_exp = 0;
    m_free = 0; m_ptr = 0; prev_rsp = '0;
    m_raddr = '0; m_waddr = '0; m_wdata = '0; m_rdata = '0;
    for (int k = 0; k < MAXC; k++) begin
      e_ren[k] = 1'b0; e_wen[k] = 1'b0; e_rsp[k] = '0; e_addr[k] = '0; e_data[k] = '0; e_rdata[k] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      c_v[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0;
    end

    // Reset; the first free cycle checks all-zero outputs.
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    // Single read by requester 0.
    arm(0, 1'b0, 20'h00005, 8'h00);
    run(6);
    check("single_read_data", 32'(rsp_rdata), 32'(init_val(20'h00005)));

    // Single write by requester 1, then readback by requester 0.
    arm(1, 1'b1, 20'h00010, 8'hA5);
    run(4);
    arm(0, 1'b0, 20'h00010, 8'h00);
    run(5);
    check("readback_A5", 32'(rsp_rdata), 32'hA5);

    // Contention: both requesters read continuously after a fresh reset.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    dut_acc.delete(); dut_cyc.delete();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!c_v[i]) arm(i, 1'b0, 20'($urandom_range(0, 31)), 8'h00);
      step();
    end
    for (int i = 0; i < NREQ; i++) c_v[i] = 1'b0;
    run(4);
    check("contention_grants", 32'(dut_acc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < dut_acc.size()) begin
`ifdef DRAM_ARB_RR_EN
        check("contention_order", 32'(dut_acc[k]), 32'(k % 2));
`else
        check("contention_order", 32'(dut_acc[k]), 32'd0);
`endif
        if (k > 0) check("contention_spacing", 32'(dut_cyc[k] - dut_cyc[k-1]), 32'd3);
      end
    end

    // Back-pressure: a write and a read requested together, both held while busy.
    arm(0, 1'b1, 20'h00020, 8'h3C);
    arm(1, 1'b0, 20'h00020, 8'h00);
    run(8);
    check("backpressure_rdata", 32'(rsp_rdata), 32'h3C);

    // Reset during WAIT abandons the read; a fresh read then completes.
    n0 = rsp_seen;
    arm(0, 1'b0, 20'h00033, 8'h00);
    run(2);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);
    check("rst_mid_no_rsp", 32'(rsp_seen), 32'(n0));
    arm(0, 1'b0, 20'h00033, 8'h00);
    run(5);
    check("rst_mid_fresh_rsp", 32'(rsp_seen), 32'(n0 + 1));
    check("rst_mid_fresh_data", 32'(rsp_rdata), 32'(init_val(20'h00033)));

    // Randomized traffic with withdrawals and occasional resets.
    for (int t = 0; t < 1200; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!c_v[i] && $urandom_range(0, 3) == 0)
          arm(i, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), 8'($urandom));
        else if (c_v[i] && $urandom_range(0, 15) == 0)
          c_v[i] = 1'b0;
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) c_v[i] = 1'b0;
    run(5);
    check("response_count", 32'(rsp_seen), 32'(rsp_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NREQ, 2, number of requesters sharing one dram_ori instance; legal values 2..4.
REQ-002 Parameter AW, 20, address width, matching dram_ori raddr/waddr.
REQ-003 Parameter DW, 8, data width, matching dram_ori wdata/rdata.
REQ-004 Ports (clock and reset first):
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_we  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*AW  packed addresses; requester i in bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  one-hot command accept.
- rsp_valid  out  NREQ  one-cycle read-response pulse per requester.
- rsp_rdata  out  DW  read data, shared and qualified by rsp_valid.
- mem_ren  out  1  to dram_ori ren.
- mem_wen  out  1  to dram_ori wen.
- mem_raddr  out  AW  to dram_ori raddr.
- mem_waddr  out  AW  to dram_ori waddr.
- mem_wdata  out  DW  to dram_ori wdata.
- mem_rdata  in  DW  from dram_ori rdata; valid the cycle after mem_ren is sampled high.

Function
REQ-005 Handshake on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-006 FSM states: IDLE, ISSUE, WAIT; only one command is in flight at a time.
REQ-007 req_ready is nonzero only in IDLE, is at most one-hot, and goes to the arbitration winner among asserted req_valid bits.
REQ-008 IDLE->ISSUE on a handshake; the winner's we/addr/wdata and index are registered; otherwise remain in IDLE.
REQ-009 ISSUE, one cycle: drive mem_wen (write) or mem_ren (read) high, with the registered address on mem_waddr or mem_raddr and data on mem_wdata.
REQ-010 ISSUE->IDLE for writes; ISSUE->WAIT for reads.
REQ-011 WAIT, one cycle: capture mem_rdata into rsp_rdata; next cycle rsp_valid[idx]=1 for exactly one cycle; state returns to IDLE.
REQ-012 Latency, handshake at cycle T: write pulse at T+1, next accept no earlier than T+2; read pulse at T+1, rsp_valid at T+3, next accept no earlier than T+3.
REQ-013 mem_ren and mem_wen are never high together and are 0 outside ISSUE.
REQ-014 Unused address/data outputs hold their last value; rsp_rdata holds until the next read capture.
REQ-015 A requester deasserting req_valid before its handshake loses the request with no side effect; req_valid asserted outside IDLE waits.

Reset
REQ-016 On rst sampled high: state=IDLE, req_ready=0, rsp_valid=0, mem_ren=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, rsp_rdata=0, round-robin pointer=0.
REQ-017 Reset during ISSUE or WAIT abandons the operation: no rsp_valid for it, and no memory strobe from the next edge on.

Configuration
REQ-018 Macro DRAM_ARB_RR_EN defined: round-robin arbitration; the pointer moves to (winner+1) mod NREQ after each handshake, and the search starts at the pointer.
REQ-019 Macro undefined: fixed priority, lowest index wins; pointer logic is absent.

Structure
REQ-020 Package dram_arb_pkg holds the AW/DW default constants and the state enum type (IDLE, ISSUE, WAIT).
REQ-021 One sub-module, rr_grant: combinational NREQ-wide one-hot grant from request vector and pointer; a fixed-priority variant is selected by the macro.

Verification
REQ-022 Single read: after reset, req0 reads addr 0x00005 -> mem_ren=1 with mem_raddr=0x00005 at T+1; rsp_valid[0]=1 at T+3 with rsp_rdata=mem_rdata sampled at T+2.
REQ-023 Single write: req1 writes 0xA5 to 0x00010 -> mem_wen=1, mem_waddr=0x00010, mem_wdata=0xA5 at T+1; no rsp_valid; readback by req0 returns 0xA5.
REQ-024 Contention, RR on: both requesters valid continuously for reads -> grants alternate 0,1,0,1; each read completes in 3 cycles. RR off: requester 0 wins every time.
REQ-025 Back-pressure: req_valid held while the FSM is busy -> req_ready stays 0 until IDLE; no command is dropped or duplicated.
REQ-026 Reset mid-read: assert rst during WAIT -> no rsp_valid; all outputs zero next cycle; a fresh read then completes normally.
REQ-027 Assertions checked every cycle: req_ready one-hot or zero; mem_ren and mem_wen never both 1; rsp_valid a single-cycle pulse.
